// File: rtl/irq_timer_gen.sv
// irq_timer_gen: line-derived tick counter driving per-channel IRQ/NMI
// sources, with CPU-mapped mask/ack/config/bank registers and status read.
module irq_timer_gen #(
    parameter int          NCH     = 3,
    parameter int          TW      = 9,
    parameter int          LSH     = 4,
    parameter int          BKW     = 3,
    parameter logic [15:0] MASK_AD = 16'hE044,
    parameter logic [15:0] BANK_AD = 16'hF000,
    parameter logic [15:0] ACK_AD  = 16'hE045,
    parameter logic [15:0] STAT_AD = 16'hE046,
    parameter logic [15:0] CFG_AD  = 16'hE048
) (
    input  logic           CPUCL,
    input  logic           RESET_n,
    input  logic [8:0]     PV,
    input  logic [15:0]    CPUAD,
    input  logic [7:0]     CPUWD,
    input  logic           CPUWE,
    input  logic           CPURE,
    output logic           cpu_irq,
    output logic           cpu_nmi,
    output logic [BKW-1:0] ROMBK,
    output logic [NCH-1:0] PEND,
    output logic           STDV,
    output logic [7:0]     STRD
);

    localparam logic [4:0] TW5 = 5'(TW);

    logic [TW-1:0]  tick_q, tick_d;
    logic           sync_q, sync_d;
    logic [8:0]     ppv_q, ppv_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [BKW-1:0] bank_q, bank_d;
    logic [4:0]     cfg_q [NCH];
    logic [4:0]     cfg_d [NCH];

    logic           we_mask, we_ack, we_bank, we_cfg, wr_any;
    logic [15:0]    cfg_off;
    logic           line_ev;
    logic [TW-1:0]  rise;
    logic [15:0]    rise16;
    logic [NCH-1:0] fire;
    logic [NCH-1:0] route;

    // Register power-on config: ch0 is the NMI heartbeat, others IRQ.
    function automatic logic [4:0] cfg_rst(int c);
        case (c)
            0:       cfg_rst = 5'b1_0000;
            1:       cfg_rst = 5'b0_0011;
            2:       cfg_rst = 5'b0_0100;
            default: cfg_rst = 5'b0_1111;
        endcase
    endfunction

    assign we_mask = CPUWE & (CPUAD == MASK_AD);
    assign we_ack  = CPUWE & (CPUAD == ACK_AD);
    assign we_bank = CPUWE & (CPUAD == BANK_AD);
    assign cfg_off = CPUAD - CFG_AD;
    assign we_cfg  = CPUWE & (cfg_off < 16'(NCH));
    assign wr_any  = we_mask | we_ack | we_bank | we_cfg;

    assign line_ev = (PV != ppv_q) && (PV[LSH-1:0] == '0);
    assign rise    = ~tick_q & (tick_q + TW'(1));
    assign rise16  = 16'(rise);

    // Per-channel fire condition and routing, out-of-range selects masked.
    always_comb begin
        fire  = '0;
        route = '0;
        for (int c = 0; c < NCH; c++) begin
            route[c] = cfg_q[c][4];
            fire[c]  = rise16[cfg_q[c][3:0]] & mask_q[c]
                     & ({1'b0, cfg_q[c][3:0]} < TW5);
        end
    end

    // Next state: CPU writes win; a colliding line event waits a cycle.
    always_comb begin
        tick_d = tick_q;
        sync_d = sync_q;
        ppv_d  = ppv_q;
        mask_d = mask_q;
        pend_d = pend_q;
        bank_d = bank_q;
        cfg_d  = cfg_q;
        if (wr_any) begin
            if (we_mask) begin
                mask_d = CPUWD[NCH-1:0];
                pend_d = pend_d & CPUWD[NCH-1:0];
            end
            if (we_ack) begin
                pend_d = pend_d & ~CPUWD[NCH-1:0];
            end
            if (we_bank) begin
                bank_d = CPUWD[7:8-BKW];
            end
            for (int c = 0; c < NCH; c++) begin
                if (we_cfg && (cfg_off == 16'(c))) begin
                    cfg_d[c] = CPUWD[4:0];
                end
            end
        end else if (line_ev) begin
            ppv_d = PV;
            if (sync_q && (PV == 9'd0)) begin
                tick_d = '0;
                sync_d = 1'b0;
            end else begin
                tick_d = tick_q + TW'(1);
            end
            pend_d = fire;
        end
    end

    // State register, updated on the falling CPU clock edge.
    always_ff @(negedge CPUCL or negedge RESET_n) begin
        if (!RESET_n) begin
            tick_q <= '0;
            sync_q <= 1'b1;
            ppv_q  <= 9'h1FF;
            mask_q <= '0;
            pend_q <= '0;
            bank_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                cfg_q[c] <= cfg_rst(c);
            end
        end else begin
            tick_q <= tick_d;
            sync_q <= sync_d;
            ppv_q  <= ppv_d;
            mask_q <= mask_d;
            pend_q <= pend_d;
            bank_q <= bank_d;
            cfg_q  <= cfg_d;
        end
    end

    assign cpu_nmi = |(pend_q & route);
    assign cpu_irq = |(pend_q & ~route);
    assign ROMBK   = bank_q;
    assign PEND    = pend_q;
    assign STDV    = CPURE & (CPUAD == STAT_AD);
    assign STRD    = 8'(pend_q);

endmodule

// File: tb/tb_irq_timer_gen.sv
// tb_irq_timer_gen: directed checks of tick/irq generation, register
// writes, write/event collision, status read and async reset.
module tb_irq_timer_gen;

    localparam int NCH = 4;
    localparam int BKW = 3;

    logic           CPUCL;
    logic           RESET_n;
    logic [8:0]     PV;
    logic [15:0]    CPUAD;
    logic [7:0]     CPUWD;
    logic           CPUWE;
    logic           CPURE;
    logic           cpu_irq;
    logic           cpu_nmi;
    logic [BKW-1:0] ROMBK;
    logic [NCH-1:0] PEND;
    logic           STDV;
    logic [7:0]     STRD;

    int checks   = 0;
    int failures = 0;

    irq_timer_gen #(
        .NCH(NCH), .TW(9), .LSH(4), .BKW(BKW)
    ) dut (
        .CPUCL  (CPUCL),
        .RESET_n(RESET_n),
        .PV     (PV),
        .CPUAD  (CPUAD),
        .CPUWD  (CPUWD),
        .CPUWE  (CPUWE),
        .CPURE  (CPURE),
        .cpu_irq(cpu_irq),
        .cpu_nmi(cpu_nmi),
        .ROMBK  (ROMBK),
        .PEND   (PEND),
        .STDV   (STDV),
        .STRD   (STRD)
    );

    initial CPUCL = 1'b1;
    always #5 CPUCL = ~CPUCL;

    initial begin
        #1000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clk();
        @(negedge CPUCL);
        #1;
    endtask

    task automatic wr(logic [15:0] a, logic [7:0] d);
        CPUAD = a;
        CPUWD = d;
        CPUWE = 1'b1;
        clk();
        CPUWE = 1'b0;
        CPUAD = 16'h0000;
        CPUWD = 8'h00;
    endtask

    task automatic chk3(string tag, logic [3:0] p, logic i, logic n);
        chk({tag, ".pend"}, 32'(PEND), 32'(p));
        chk({tag, ".irq"}, 32'(cpu_irq), 32'(i));
        chk({tag, ".nmi"}, 32'(cpu_nmi), 32'(n));
    endtask

    // Sweep checkpoints: sweep, PV, expected PEND, irq, nmi.
    int         pt_sw [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    int         pt_pv [13] = '{0, 16, 32, 128, 143, 144, 256, 384,
                               0, 16, 128, 256, 511};
    logic [3:0] pt_pe [13] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h1, 4'h4,
                               4'h2, 4'h0, 4'h1, 4'h2, 4'h4, 4'h1};
    logic       pt_ir [13] = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0};
    logic       pt_nm [13] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1};

    initial begin
        RESET_n = 1'b0;
        PV      = 9'd1;
        CPUAD   = 16'h0000;
        CPUWD   = 8'h00;
        CPUWE   = 1'b0;
        CPURE   = 1'b0;
        clk();
        clk();
        chk3("rst", 4'h0, 1'b0, 1'b0);
        chk("rst.rombk", 32'(ROMBK), 32'h0);
        chk("rst.stdv", 32'(STDV), 32'h0);
        RESET_n = 1'b1;

        wr(16'hE044, 8'h07);
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 512; p++) begin
                PV = 9'(p);
                clk();
                for (int i = 0; i < 13; i++) begin
                    if (pt_sw[i] == s && pt_pv[i] == p) begin
                        chk3($sformatf("sweep%0d.pv%0d", s, p),
                             pt_pe[i], pt_ir[i], pt_nm[i]);
                    end
                end
            end
        end

        wr(16'hE044, 8'h06);
        chk3("mask06", 4'h0, 1'b0, 1'b0);

        RESET_n = 1'b0;
        clk();
        RESET_n = 1'b1;
        wr(16'hE044, 8'h02);
        for (int k = 0; k < 8; k++) begin
            PV = 9'(16 * k);
            clk();
        end
        chk3("pre_ack", 4'h0, 1'b0, 1'b0);
        PV    = 9'd128;
        CPUAD = 16'hE045;
        CPUWD = 8'h02;
        CPUWE = 1'b1;
        clk();
        CPUWE = 1'b0;
        CPUAD = 16'h0000;
        chk3("ack_collide", 4'h0, 1'b0, 1'b0);
        clk();
        chk3("deferred_ev", 4'h2, 1'b1, 1'b0);
        wr(16'hE045, 8'h02);
        chk3("ack_clear", 4'h0, 1'b0, 1'b0);

        wr(16'hE04B, 8'h11);
        wr(16'hE044, 8'h08);
        PV = 9'd144;
        clk();
        chk3("ch3.pv144", 4'h0, 1'b0, 1'b0);
        PV = 9'd160;
        clk();
        chk3("ch3.pv160", 4'h8, 1'b0, 1'b1);
        CPURE = 1'b1;
        CPUAD = 16'hE046;
        #1;
        chk("stat.stdv", 32'(STDV), 32'h1);
        chk("stat.strd", 32'(STRD), 32'h08);
        clk();
        chk("stat.nochg", 32'(PEND), 32'h8);
        CPUAD = 16'hE045;
        #1;
        chk("stat.badad", 32'(STDV), 32'h0);
        CPURE = 1'b0;
        CPUAD = 16'hE046;
        #1;
        chk("stat.nore", 32'(STDV), 32'h0);
        CPUAD = 16'h0000;
        for (int v = 176; v <= 224; v += 16) begin
            PV = 9'(v);
            clk();
            if (v == 176) chk3("ch3.pv176", 4'h0, 1'b0, 1'b0);
        end
        chk3("ch3.pv224", 4'h8, 1'b0, 1'b1);

        wr(16'hF000, 8'hA0);
        chk("bank", 32'(ROMBK), 32'h5);
        chk("bank.pend", 32'(PEND), 32'h8);
        #2;
        RESET_n = 1'b0;
        #1;
        chk("arst.rombk", 32'(ROMBK), 32'h0);
        chk3("arst", 4'h0, 1'b0, 1'b0);
        clk();
        RESET_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
